// File: rtl/popcount_stream_neuron.sv
// Ternary neuron core: accumulates popcount(pos)-popcount(neg) over BEATS beats,
// then presents the signed sum and a fire flag (sum >= threshold latched on the first beat).
//
// Handshake: a beat transfers on a rising edge where in_valid & in_ready are both 1;
// a result transfers on a rising edge where out_valid & out_ready are both 1. A producer
// holds its valid and data stable until the transfer; the consumer's ready never
// depends on the producer's valid.
module popcount_stream_neuron #(
   parameter int IN_W  = 24,
   parameter int BEATS = 4,
   parameter int ACC_W = $clog2(IN_W*BEATS+1)+1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [ACC_W-1:0] cfg_threshold,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IN_W-1:0]         in_pos,
   input  logic [IN_W-1:0]         in_neg,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_sum,
   output logic                    out_fire,
   output logic                    busy,
   output logic [1:0]              dbg_state
);

   localparam int CNT_W = $clog2(IN_W+1);
   localparam int D_W   = CNT_W + 1;
   localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_next;

   logic [BC_W-1:0]         beat_cnt;
   logic                    accept;
   logic                    is_first;
   logic                    is_last;
   logic [CNT_W-1:0]        pc_pos;
   logic [CNT_W-1:0]        pc_neg;
   logic signed [D_W-1:0]   d_next;

   logic signed [D_W-1:0]   d_q;
   logic                    first_q;
   logic                    last_q;
   logic                    s1_valid;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [ACC_W-1:0] thr_q;

   function automatic logic [CNT_W-1:0] popcount(input logic [IN_W-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < IN_W; i++) begin
         c = c + CNT_W'(v[i]);
      end
      return c;
   endfunction

   assign in_ready  = (state == ACCUM) && !rst;
   assign accept    = in_valid && in_ready;
   assign is_first  = (beat_cnt == '0);
   assign is_last   = (beat_cnt == BC_W'(BEATS-1));
   assign out_valid = (state == DONE);
   assign busy      = !((state == ACCUM) && (beat_cnt == '0));
   assign dbg_state = state;

   // A bit set in both masks counts once on each side and cancels out.
   assign pc_pos = popcount(in_pos);
   assign pc_neg = popcount(in_neg);
   assign d_next = signed'({1'b0, pc_pos}) - signed'({1'b0, pc_neg});

   assign acc_next = (first_q ? ACC_W'(0) : acc) + ACC_W'(d_q);

   always_comb begin
      state_next = state;
      case (state)
         ACCUM: if (accept && is_last) state_next = DRAIN;
         DRAIN: if (s1_valid && last_q) state_next = DONE;
         DONE:  if (out_ready)          state_next = ACCUM;
         default:                       state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
         thr_q    <= '0;
      end else if (accept) begin
         beat_cnt <= is_last ? '0 : beat_cnt + BC_W'(1);
         if (is_first) thr_q <= cfg_threshold;
      end
   end

   // Stage 1: per-beat signed difference with its position flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_q      <= '0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            d_q     <= d_next;
            first_q <= is_first;
            last_q  <= is_last;
         end
      end
   end

   // Stage 2: accumulate; the last beat's sum is captured straight into the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         out_sum  <= '0;
         out_fire <= 1'b0;
      end else begin
         if (s1_valid) acc <= acc_next;
         if (state == DRAIN && s1_valid && last_q) begin
            out_sum  <= acc_next;
            out_fire <= (acc_next >= thr_q);
         end
      end
   end

endmodule

// File: tb/tb_popcount_stream_neuron.sv
// Directed bench for popcount_stream_neuron: driver tasks push expected results into a
// queue, a monitor pops and compares on every result handshake.
module tb_popcount_stream_neuron;

   localparam int IN_W  = 24;
   localparam int BEATS = 4;
   localparam int ACC_W = 8;

   logic                    clk;
   logic                    rst;
   logic signed [ACC_W-1:0] cfg_threshold;
   logic                    in_valid;
   logic                    in_ready;
   logic [IN_W-1:0]         in_pos;
   logic [IN_W-1:0]         in_neg;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_sum;
   logic                    out_fire;
   logic                    busy;
   logic [1:0]              dbg_state;

   logic [ACC_W:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   popcount_stream_neuron #(.IN_W(IN_W), .BEATS(BEATS), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .cfg_threshold(cfg_threshold),
      .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos), .in_neg(in_neg),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_fire(out_fire), .busy(busy), .dbg_state(dbg_state)
   );

   // Clock and reset defaults
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: compare on each result handshake, flag results nobody asked for.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out_valid", 1, 0);
         end else begin
            logic [ACC_W:0] e;
            e = exp_q.pop_front();
            check("out_sum", int'(out_sum), int'($signed(e[ACC_W-1:0])));
            check("out_fire", int'(out_fire), int'(e[ACC_W]));
         end
      end
   end

   // Driver tasks; all are entered and left just after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_beat(input logic [IN_W-1:0] p, input logic [IN_W-1:0] n,
                            input logic signed [ACC_W-1:0] thr);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_pos = p;
      in_neg = n;
      cfg_threshold = thr;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!ok) check("beat_accept_timeout", 0, 1);
   endtask

   task automatic expect_result(input int sum, input bit fire);
      logic signed [ACC_W-1:0] s;
      s = ACC_W'(sum);
      exp_q.push_back({fire, s});
   endtask

   task automatic wait_out_valid(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      if (!seen) check(name, 0, 1);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b1;
      in_pos = '1;
      in_neg = '0;
      cfg_threshold = '0;
      out_ready = 1'b1;

      // 1: reset held 3 cycles with in_valid high
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_in_ready", int'(in_ready), 0);
         check("rst_out_valid", int'(out_valid), 0);
         @(posedge clk); #1;
      end
      check("rst_out_sum", int'(out_sum), 0);
      check("rst_out_fire", int'(out_fire), 0);
      check("rst_busy", int'(busy), 0);
      in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      // 2: all-positive, threshold boundary, latency t_last+2
      expect_result(96, 1'b1);
      for (int b = 0; b < BEATS; b++) send_beat(24'hFFFFFF, 24'h0, 8'sd96);
      @(negedge clk);
      check("latency_t1_out_valid", int'(out_valid), 0);
      @(negedge clk);
      check("latency_t2_out_valid", int'(out_valid), 1);
      @(posedge clk); #1;

      // 3: all-negative, then cancelling masks
      expect_result(-96, 1'b0);
      for (int b = 0; b < BEATS; b++) send_beat(24'h0, 24'hFFFFFF, 8'sd0);
      idle(3);
      expect_result(0, 1'b1);
      for (int b = 0; b < BEATS; b++) send_beat(24'h00F0F0, 24'h00F0F0, 8'sd0);
      idle(3);

      // 4: gapped beats; threshold changed mid-evaluation must not matter
      expect_result(8, 1'b0);
      for (int b = 0; b < BEATS; b++) begin
         send_beat(24'h000007, 24'h000001, (b == 0) ? 8'sd9 : 8'sd0);
         idle(1 + b % 3);
      end
      idle(3);
      expect_result(8, 1'b0);
      for (int b = 0; b < BEATS; b++) send_beat(24'h000007, 24'h000001, 8'sd9);
      idle(3);

      // 5: back-pressure in DONE for 5 cycles with beats offered
      out_ready = 1'b0;
      expect_result(8, 1'b1);
      for (int b = 0; b < BEATS; b++) send_beat(24'h000003, 24'h0, 8'sd8);
      wait_out_valid("hold_out_valid_timeout");
      in_valid = 1'b1;
      in_pos = 24'hFFFFFF;
      in_neg = 24'h0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("hold_out_valid", int'(out_valid), 1);
         check("hold_out_sum", int'(out_sum), 8);
         check("hold_out_fire", int'(out_fire), 1);
         check("hold_in_ready", int'(in_ready), 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("release_in_ready", int'(in_ready), 1);
      check("release_out_valid", int'(out_valid), 0);
      check("release_out_sum_kept", int'(out_sum), 8);
      @(posedge clk); #1;

      // 6: reset mid-evaluation, then a clean evaluation
      send_beat(24'hFFFFFF, 24'h0, 8'sd0);
      send_beat(24'hFFFFFF, 24'h0, 8'sd0);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      @(posedge clk); #1;
      idle(4);
      expect_result(4, 1'b1);
      for (int b = 0; b < BEATS; b++) send_beat(24'h000001, 24'h0, 8'sd4);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
      if (exp_q.size() != 0) check("scoreboard_drain_timeout", exp_q.size(), 0);
      idle(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
